pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage 16-bit CPU.
- Generates write enables and flushes for the PC register, F/D flops and later stage flops (D/X, X/M, M/W).
- Resolves, in priority order: data-memory wait stalls, load-use hazards, decode-stage taken branches, and halt draining.
- Owns the sticky processor-halted indication.

Parameters:
- REG_W, 4: register-specifier width.
- DRAIN_CYCLES, 4: non-stalled cycles after HLT leaves fetch before halted asserts (HLT passes D, X, M, W).

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- if_halt, input, 1: fetched instruction opcode is 4'b1111.
- fd_rs, input, REG_W: source register 1 of the instruction in decode.
- fd_rt, input, REG_W: source register 2 of the instruction in decode.
- fd_uses_rs, input, 1: decode instruction reads rs.
- fd_uses_rt, input, 1: decode instruction reads rt.
- dx_memread, input, 1: instruction in execute is LW.
- dx_rd, input, REG_W: destination register of the instruction in execute.
- br_taken, input, 1: decode-stage branch (B/BR) resolved taken.
- mem_stall, input, 1: data memory not ready this cycle.
- pc_wen, output, 1: PC register write enable.
- fd_wen, output, 1: F/D flop write enable.
- fd_flush, output, 1: F/D captures NOP (0x0000) instead of instruction_in.
- dx_flush, output, 1: D/X captures bubble (all control bits 0).
- pipe_wen, output, 1: shared write enable for D/X, X/M, M/W flops.
- halted, output, 1: registered, sticky halt flag.

Behaviour:
- State register {RUN, DRAIN, HALTED} plus drain counter cnt ($clog2(DRAIN_CYCLES+1) bits). Both are async-cleared when rst=0 to RUN, cnt=0.
- pc_wen, fd_wen, fd_flush, dx_flush and pipe_wen are combinational from state and inputs. While rst=0 all of them are 0. halted is a flop that resets to 0.
- Load-use hazard lu = dx_memread & (dx_rd != 0) & ((fd_uses_rs & dx_rd==fd_rs) | (fd_uses_rt & dx_rd==fd_rt)). R0 never hazards.
- RUN, priority highest first:
  - mem_stall: pc_wen=fd_wen=pipe_wen=0, no flushes. br_taken, lu and if_halt are ignored; the state holds.
  - lu: pc_wen=0, fd_wen=0, dx_flush=1, pipe_wen=1. Exactly one bubble per LW hazard. br_taken is ignored this cycle because decode is not yet valid.
  - br_taken: pc_wen=1, fd_wen=1, fd_flush=1, pipe_wen=1. A HLT in fetch in the same cycle is squashed and the state stays RUN.
  - if_halt: pc_wen=0, fd_wen=1, pipe_wen=1. Next state is DRAIN with cnt=DRAIN_CYCLES-1.
  - else: pc_wen=fd_wen=pipe_wen=1, no flushes.
- DRAIN:
  - Outputs: pc_wen=0, fd_wen=1, fd_flush=1, pipe_wen=!mem_stall.
  - When mem_stall=1: fd_wen=0, cnt holds.
  - Otherwise: if cnt==0, next state is HALTED and halted<=1; else cnt decrements.
  - lu and br_taken are ignored in DRAIN. No instruction younger than HLT exists.
- HALTED: all enables 0, no flushes, halted=1. Leaves only on reset.
- Total: HLT fetched at cycle T with no stalls gives halted=1 visible at cycle T+DRAIN_CYCLES+1.
- Reset mid-DRAIN or in HALTED returns immediately to RUN with halted=0.
- Simultaneous mem_stall and lu: the freeze wins, and the lu bubble is inserted on the first non-stalled cycle if the hazard persists.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_LW=4'b1000, OP_SW=4'b1001, OP_B=4'b1100, OP_BR=4'b1101, OP_HLT=4'b1111;
  - the ctrl_state_t enum {RUN, DRAIN, HALTED};
  - NOP_INSTR=16'h0000.
- One natural sub-module: hazard_detect, combinational, computing lu from fd/dx fields. The FSM stays in the top.

Test Plan:
- Load-use: LW R3 in X, decode ADD R1,R3,R2 (uses_rs, rs=3) -> exactly one cycle of pc_wen=0, fd_wen=0, dx_flush=1, then normal flow. Repeat with dx_rd=0 -> no stall.
- Taken branch: br_taken=1 with if_halt=1 in the same cycle -> fd_flush=1, pc_wen=1, state stays RUN, halted never asserts.
- Halt drain: if_halt=1 at cycle 10, no stalls -> pc_wen=0 from cycle 10, fd_flush=1 for cycles 11-14, halted=1 at cycle 15 and stays 1 for 20 further cycles.
- Memory freeze: mem_stall=1 for 3 cycles during DRAIN with cnt=2 -> pipe_wen=0 and cnt held for those cycles; halted is delayed by exactly 3 cycles.
- Stall priority: mem_stall=1 with lu=1 -> no dx_flush while stalled. Bubble appears the cycle after mem_stall drops.
- Async reset: rst pulled low mid-cycle in HALTED -> halted=0 and all enables 0 immediately. After rst=1, normal RUN with pc_wen=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage 16-bit CPU: opcodes, the pipeline control
// state and the NOP encoding.
package cpu_pkg;

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a LW in execute whose destination is read by the
// instruction in decode. R0 is hardwired to zero and so never hazards.
module hazard_detect #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] fd_rs,
  input  logic [REG_W-1:0] fd_rt,
  input  logic             fd_uses_rs,
  input  logic             fd_uses_rt,
  input  logic             dx_memread,
  input  logic [REG_W-1:0] dx_rd,
  output logic             lu
);

  logic rs_match;
  logic rt_match;

  assign rs_match = fd_uses_rs && (dx_rd == fd_rs);
  assign rt_match = fd_uses_rt && (dx_rd == fd_rt);
  assign lu       = dx_memread && (dx_rd != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: stage enables and flushes for memory stalls,
// load-use bubbles, decode-stage branches and halt draining; owns halted.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W        = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_halt,
  input  logic [REG_W-1:0] fd_rs,
  input  logic [REG_W-1:0] fd_rt,
  input  logic             fd_uses_rs,
  input  logic             fd_uses_rt,
  input  logic             dx_memread,
  input  logic [REG_W-1:0] dx_rd,
  input  logic             br_taken,
  input  logic             mem_stall,
  output logic             pc_wen,
  output logic             fd_wen,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             pipe_wen,
  output logic             halted
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  ctrl_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             lu;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .fd_rs      (fd_rs),
    .fd_rt      (fd_rt),
    .fd_uses_rs (fd_uses_rs),
    .fd_uses_rt (fd_uses_rt),
    .dx_memread (dx_memread),
    .dx_rd      (dx_rd),
    .lu         (lu)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    pc_wen   = 1'b0;
    fd_wen   = 1'b0;
    fd_flush = 1'b0;
    dx_flush = 1'b0;
    pipe_wen = 1'b0;
    if (rst) begin
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            // full freeze: every stage holds
          end else if (lu) begin
            dx_flush = 1'b1;
            pipe_wen = 1'b1;
          end else if (br_taken) begin
            pc_wen   = 1'b1;
            fd_wen   = 1'b1;
            fd_flush = 1'b1;
            pipe_wen = 1'b1;
          end else if (if_halt) begin
            fd_wen   = 1'b1;
            pipe_wen = 1'b1;
          end else begin
            pc_wen   = 1'b1;
            fd_wen   = 1'b1;
            pipe_wen = 1'b1;
          end
        end
        DRAIN: begin
          fd_wen   = !mem_stall;
          fd_flush = 1'b1;
          pipe_wen = !mem_stall;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      cnt    <= '0;
      halted <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (!mem_stall && !lu && !br_taken && if_halt) begin
            state <= DRAIN;
            cnt   <= CNT_LOAD;
          end
        end
        DRAIN: begin
          if (!mem_stall) begin
            if (cnt == '0) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a behavioural model checked every cycle
// plus hand-computed expectations for the load-use, branch, halt and reset cases.
module tb_pipe_hazard_ctrl;

  localparam int REG_W        = 4;
  localparam int DRAIN_CYCLES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             if_halt;
  logic [REG_W-1:0] fd_rs, fd_rt, dx_rd;
  logic             fd_uses_rs, fd_uses_rt, dx_memread, br_taken, mem_stall;
  logic             pc_wen, fd_wen, fd_flush, dx_flush, pipe_wen, halted;

  int vectors     = 0;
  int miscompares = 0;

  pipe_hazard_ctrl #(.REG_W(REG_W), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_halt    (if_halt),
    .fd_rs      (fd_rs),
    .fd_rt      (fd_rt),
    .fd_uses_rs (fd_uses_rs),
    .fd_uses_rt (fd_uses_rt),
    .dx_memread (dx_memread),
    .dx_rd      (dx_rd),
    .br_taken   (br_taken),
    .mem_stall  (mem_stall),
    .pc_wen     (pc_wen),
    .fd_wen     (fd_wen),
    .fd_flush   (fd_flush),
    .dx_flush   (dx_flush),
    .pipe_wen   (pipe_wen),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Behavioural model: halting is tracked as "non-stalled drain cycles still owed".
  bit m_draining, m_halted;
  int m_left;
  bit m_lu;
  bit e_pc, e_fdw, e_fdf, e_dxf, e_pipe;

  always_comb begin
    m_lu = dx_memread && (dx_rd != 0) &&
           ((fd_uses_rs && dx_rd == fd_rs) || (fd_uses_rt && dx_rd == fd_rt));
    {e_pc, e_fdw, e_fdf, e_dxf, e_pipe} = 5'b00000;
    if (rst !== 1'b1 || m_halted) begin
      {e_pc, e_fdw, e_fdf, e_dxf, e_pipe} = 5'b00000;
    end else if (m_draining) begin
      {e_pc, e_fdw, e_fdf, e_dxf, e_pipe} = {1'b0, !mem_stall, 1'b1, 1'b0, !mem_stall};
    end else if (mem_stall) begin
      {e_pc, e_fdw, e_fdf, e_dxf, e_pipe} = 5'b00000;
    end else if (m_lu) begin
      {e_pc, e_fdw, e_fdf, e_dxf, e_pipe} = 5'b00011;
    end else if (br_taken) begin
      {e_pc, e_fdw, e_fdf, e_dxf, e_pipe} = 5'b11101;
    end else if (if_halt) begin
      {e_pc, e_fdw, e_fdf, e_dxf, e_pipe} = 5'b01001;
    end else begin
      {e_pc, e_fdw, e_fdf, e_dxf, e_pipe} = 5'b11001;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_draining <= 1'b0;
      m_halted   <= 1'b0;
      m_left     <= 0;
    end else if (m_halted) begin
      m_halted <= 1'b1;
    end else if (m_draining) begin
      if (!mem_stall) begin
        if (m_left == 1) begin
          m_draining <= 1'b0;
          m_halted   <= 1'b1;
        end
        m_left <= m_left - 1;
      end
    end else if (!mem_stall && !m_lu && !br_taken && if_halt) begin
      m_draining <= 1'b1;
      m_left     <= DRAIN_CYCLES;
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("model_pc_wen",   pc_wen,   e_pc);
    check("model_fd_wen",   fd_wen,   e_fdw);
    check("model_fd_flush", fd_flush, e_fdf);
    check("model_dx_flush", dx_flush, e_dxf);
    check("model_pipe_wen", pipe_wen, e_pipe);
    check("model_halted",   halted,   m_halted);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_halt = 0; fd_rs = 0; fd_rt = 0; fd_uses_rs = 0; fd_uses_rt = 0;
    dx_memread = 0; dx_rd = 0; br_taken = 0; mem_stall = 0;
  endtask

  // Drop reset mid-cycle, check outputs clear at once, release at the next cycle.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check({tag, "_rst_halted"},   halted,   1'b0);
    check({tag, "_rst_pc_wen"},   pc_wen,   1'b0);
    check({tag, "_rst_fd_wen"},   fd_wen,   1'b0);
    check({tag, "_rst_pipe_wen"}, pipe_wen, 1'b0);
    tick();
    rst = 1'b1;
  endtask

  task automatic set_lw_hazard(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs);
    dx_memread = 1; dx_rd = rd; fd_rs = rs; fd_uses_rs = 1;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    tick();
    #2;
    check("reset_pc_wen", pc_wen, 1'b0);
    check("reset_halted", halted, 1'b0);
    tick();
    rst = 1'b1;
    #2;
    check("run_pc_wen", pc_wen, 1'b1);
    tick();

    // Load-use on rs: one bubble, then normal flow.
    set_lw_hazard(4'd3, 4'd3);
    #2;
    check("lu_pc_wen",   pc_wen,   1'b0);
    check("lu_fd_wen",   fd_wen,   1'b0);
    check("lu_dx_flush", dx_flush, 1'b1);
    check("lu_pipe_wen", pipe_wen, 1'b1);
    tick();
    dx_memread = 0;
    #2;
    check("lu_after_pc_wen",   pc_wen,   1'b1);
    check("lu_after_dx_flush", dx_flush, 1'b0);
    tick();

    // Destination R0 never hazards.
    set_lw_hazard(4'd0, 4'd0);
    #2;
    check("lu_r0_pc_wen",   pc_wen,   1'b1);
    check("lu_r0_dx_flush", dx_flush, 1'b0);
    tick();

    // Hazard through rt only; rs unused so its match must not count.
    idle_inputs();
    dx_memread = 1; dx_rd = 4'd7; fd_rt = 4'd7; fd_uses_rt = 1; fd_rs = 4'd7;
    #2;
    check("lu_rt_dx_flush", dx_flush, 1'b1);
    tick();
    fd_uses_rt = 0;
    #2;
    check("lu_rs_unused_pc_wen", pc_wen, 1'b1);
    tick();
    idle_inputs();

    // Taken branch squashes a HLT in fetch.
    br_taken = 1; if_halt = 1;
    #2;
    check("br_fd_flush", fd_flush, 1'b1);
    check("br_pc_wen",   pc_wen,   1'b1);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #2;
      check("br_stays_run_pc_wen", pc_wen, 1'b1);
      check("br_no_halted",        halted, 1'b0);
      tick();
    end

    // Branch together with a load-use: the bubble wins.
    set_lw_hazard(4'd5, 4'd5);
    br_taken = 1;
    #2;
    check("lu_over_br_fd_flush", fd_flush, 1'b0);
    check("lu_over_br_dx_flush", dx_flush, 1'b1);
    tick();
    idle_inputs();

    // Stall priority: freeze while stalled, bubble once the stall drops.
    set_lw_hazard(4'd2, 4'd2);
    mem_stall = 1;
    for (int i = 0; i < 2; i++) begin
      #2;
      check("stall_dx_flush", dx_flush, 1'b0);
      check("stall_pipe_wen", pipe_wen, 1'b0);
      check("stall_pc_wen",   pc_wen,   1'b0);
      tick();
    end
    mem_stall = 0;
    #2;
    check("stall_then_bubble", dx_flush, 1'b1);
    tick();
    idle_inputs();
    tick();

    // Halt drain: HLT at T, flush T+1..T+4, halted from T+5.
    if_halt = 1;
    #2;
    check("hlt_pc_wen",   pc_wen,   1'b0);
    check("hlt_fd_wen",   fd_wen,   1'b1);
    check("hlt_fd_flush", fd_flush, 1'b0);
    tick();
    if_halt = 0;
    for (int i = 1; i <= DRAIN_CYCLES; i++) begin
      if (i == 2) begin
        br_taken = 1;
        set_lw_hazard(4'd4, 4'd4);
      end else begin
        idle_inputs();
      end
      #2;
      check("drain_fd_flush", fd_flush, 1'b1);
      check("drain_pc_wen",   pc_wen,   1'b0);
      check("drain_dx_flush", dx_flush, 1'b0);
      check("drain_halted",   halted,   1'b0);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 20; i++) begin
      #2;
      check("halted_sticky",  halted,   1'b1);
      check("halted_pc_wen",  pc_wen,   1'b0);
      check("halted_pipe_wen", pipe_wen, 1'b0);
      tick();
    end

    async_reset("halted");
    #2;
    check("post_reset_pc_wen", pc_wen, 1'b1);
    check("post_reset_halted", halted, 1'b0);
    tick();

    // Freeze during drain at cnt=2: halted delayed by exactly 3 cycles (T+8).
    if_halt = 1;
    tick();
    if_halt = 0;
    tick();
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("frz_pipe_wen", pipe_wen, 1'b0);
      check("frz_fd_wen",   fd_wen,   1'b0);
      tick();
    end
    mem_stall = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("frz_not_yet_halted", halted,   1'b0);
      check("frz_pipe_wen_back",  pipe_wen, 1'b1);
      tick();
    end
    #2;
    check("frz_halted_delayed", halted, 1'b1);
    tick();

    // Reset in the middle of a drain.
    async_reset("halted2");
    if_halt = 1;
    tick();
    if_halt = 0;
    tick();
    async_reset("drain");
    #2;
    check("drain_reset_run", pc_wen, 1'b1);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
